lc3_mem_responder: RTL and testbench

- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- Accepts the control unit's Mem_OE/Mem_WE strobes with the MAR address and MDR write data.
- Services them from an on-chip word array with fixed, parameterised wait states, and returns read data for MDR.
- Also decodes one memory-mapped I/O word (switches in, hex-display register out).
- Sits between the CPU datapath and the board-level I/O.

---
 rtl/lc3_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_lc3_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder: word array with fixed wait states,
// plus one memory-mapped word (switches in, hex-display register out).
module lc3_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 2,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_mem,
    input  logic [15:0] Switches,
    output logic [15:0] Data_from_mem,
    output logic        Mem_Ready,
    output logic [15:0] HEX_out,
    output logic        Proto_Err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] RD_CNT0 = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_CNT0 = CW'(WR_WAIT - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_WR_WAIT,
        S_WR_HOLD
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    dout_q, dout_d;
    logic [15:0]    hex_q, hex_d;
    logic           rdy_q, rdy_d;
    logic           perr_q, perr_d;
    logic [15:0]    sw_meta_q, sw_sync_q;
    logic [15:0]    mem_q [DEPTH];

    logic [15:0]    cur_addr, cur_wdata, rd_word;
    logic           ld, commit, mem_we;

    // The start edge acts on the live bus; later edges use the captured copy.
    assign cur_addr  = (state_q == S_IDLE) ? ADDR : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? Data_to_mem : wdata_q;
    assign rd_word   = (cur_addr == IO_ADDR) ? sw_sync_q
                                             : mem_q[cur_addr[AW-1:0]];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (Mem_WE) begin
                    state_d = (WR_WAIT == 1) ? S_WR_HOLD : S_WR_WAIT;
                end else if (Mem_OE) begin
                    state_d = (RD_WAIT == 1) ? S_RD_HOLD : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (!Mem_OE)           state_d = S_IDLE;
                else if (cnt_q <= ONE) state_d = S_RD_HOLD;
            end
            S_RD_HOLD: if (!Mem_OE) state_d = S_IDLE;
            S_WR_WAIT: begin
                if (!Mem_WE)           state_d = S_IDLE;
                else if (cnt_q <= ONE) state_d = S_WR_HOLD;
            end
            S_WR_HOLD: if (!Mem_WE) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        hex_d   = hex_q;
        perr_d  = perr_q;
        ld      = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Mem_WE) begin
                    addr_d  = ADDR;
                    wdata_d = Data_to_mem;
                    cnt_d   = WR_CNT0;
                    if (Mem_OE) perr_d = 1'b1;
                    if (WR_WAIT == 1) commit = 1'b1;
                end else if (Mem_OE) begin
                    addr_d = ADDR;
                    cnt_d  = RD_CNT0;
                    if (RD_WAIT == 1) ld = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (Mem_OE) begin
                    if (cnt_q <= ONE) ld = 1'b1;
                    else              cnt_d = cnt_q - ONE;
                end
            end
            S_RD_HOLD: if (Mem_WE) perr_d = 1'b1;
            S_WR_WAIT: begin
                if (Mem_WE) begin
                    if (cnt_q <= ONE) commit = 1'b1;
                    else              cnt_d = cnt_q - ONE;
                end
            end
            S_WR_HOLD: ;
            default: ;
        endcase
        if (ld) dout_d = rd_word;
        if (commit && cur_addr == IO_ADDR) hex_d = cur_wdata;
        rdy_d = (state_d == S_RD_HOLD) || (state_d == S_WR_HOLD);
    end

    assign mem_we = commit && (cur_addr != IO_ADDR) && Reset;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            hex_q     <= '0;
            rdy_q     <= 1'b0;
            perr_q    <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            hex_q     <= hex_d;
            rdy_q     <= rdy_d;
            perr_q    <= perr_d;
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) mem_q[cur_addr[AW-1:0]] <= cur_wdata;
    end

    assign Data_from_mem = dout_q;
    assign Mem_Ready     = rdy_q;
    assign HEX_out       = hex_q;
    assign Proto_Err     = perr_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Randomised bench for lc3_mem_responder against a word-level
// transaction model of the memory and I/O word.
module tb_lc3_mem_responder;

    localparam int RD_W = 1;
    localparam int WR_W = 2;

    logic        Clk, Reset, oe, we;
    logic [15:0] addr, din, sw;
    logic [15:0] dout, hex, dout3, hex3;
    logic        rdy, perr, rdy3, perr3;

    lc3_mem_responder u_dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe), .Mem_WE(we),
        .ADDR(addr), .Data_to_mem(din), .Switches(sw),
        .Data_from_mem(dout), .Mem_Ready(rdy),
        .HEX_out(hex), .Proto_Err(perr)
    );

    lc3_mem_responder #(.RD_WAIT(3)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe), .Mem_WE(we),
        .ADDR(addr), .Data_to_mem(din), .Switches(sw),
        .Data_from_mem(dout3), .Mem_Ready(rdy3),
        .HEX_out(hex3), .Proto_Err(perr3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [15:0] ref_mem [1024];
    bit          written [1024];
    int          wq[$];
    logic [15:0] hex_ref, dout_ref, sw_ref;
    logic        perr_ref;
    int          n_tests, n_fail;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      input int n, input bit both);
        we   = 1'b1;
        oe   = both;
        addr = a;
        din  = d;
        if (both) perr_ref = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick();
            addr = 16'($urandom);
            din  = 16'($urandom);
            chk("wr_rdy", {15'b0, rdy}, {15'b0, k >= WR_W});
        end
        if (n >= WR_W) begin
            if (a == 16'hFFFF) begin
                hex_ref = d;
            end else begin
                ref_mem[a[9:0]] = d;
                if (!written[a[9:0]]) begin
                    written[a[9:0]] = 1'b1;
                    wq.push_back(int'(a[9:0]));
                end
            end
        end
        we = 1'b0;
        oe = 1'b0;
        tick();
        chk("wr_end_rdy", {15'b0, rdy}, 16'h0);
        chk("hex", hex, hex_ref);
        chk("perr", {15'b0, perr}, {15'b0, perr_ref});
    endtask

    task automatic rd(input logic [15:0] a, input int n);
        logic [15:0] e;
        e    = (a == 16'hFFFF) ? sw_ref : ref_mem[a[9:0]];
        oe   = 1'b1;
        addr = a;
        for (int k = 1; k <= n; k++) begin
            tick();
            addr = 16'($urandom);
            if (k >= RD_W) dout_ref = e;
            chk("rd_rdy", {15'b0, rdy}, {15'b0, k >= RD_W});
            chk("rd_data", dout, dout_ref);
        end
        oe = 1'b0;
        tick();
        chk("rd_end_rdy", {15'b0, rdy}, 16'h0);
        chk("rd_hold_data", dout, dout_ref);
    endtask

    task automatic setsw(input logic [15:0] v);
        sw = v;
        tick();
        tick();
        sw_ref = v;
    endtask

    initial begin
        logic [15:0] a, d, old;
        int          r, idx;
        n_tests  = 0;
        n_fail   = 0;
        hex_ref  = 16'h0;
        dout_ref = 16'h0;
        sw_ref   = 16'h0;
        perr_ref = 1'b0;
        oe = 1'b0; we = 1'b0; addr = '0; din = '0; sw = '0;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1;
        chk("rst_data", dout, 16'h0);
        chk("rst_rdy", {15'b0, rdy}, 16'h0);
        chk("rst_hex", hex, 16'h0);
        chk("rst_perr", {15'b0, perr}, 16'h0);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        wr(16'h0010, 16'hBEEF, 2, 1'b0);
        rd(16'h0010, 2);
        wr(16'h0405, 16'h1234, 2, 1'b0);
        rd(16'h0005, 2);
        setsw(16'h00A5);
        rd(16'hFFFF, 2);
        wr(16'h03FF, 16'h5A5A, 2, 1'b0);
        wr(16'hFFFF, 16'h0C0D, 2, 1'b0);
        chk("hex_io", hex, 16'h0C0D);
        rd(16'h03FF, 2);
        wr(16'h0020, 16'h1111, 2, 1'b0);
        wr(16'h0020, 16'h7777, 1, 1'b0);
        rd(16'h0020, 2);

        // RD_WAIT=3 instance: valid after the third edge counted from start
        oe   = 1'b1;
        addr = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            tick();
            addr = 16'($urandom);
            chk("rd3_rdy", {15'b0, rdy3}, {15'b0, k >= 3});
            chk("rd3_data", dout3, (k >= 3) ? 16'hBEEF : 16'h0000);
        end
        oe = 1'b0;
        tick();
        chk("rd3_end_rdy", {15'b0, rdy3}, 16'h0);
        dout_ref = 16'hBEEF;
        rd(16'h0005, 2);
        chk("rd3_abort_data", dout3, 16'hBEEF);
        chk("rd3_abort_rdy", {15'b0, rdy3}, 16'h0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                wr(16'($urandom), 16'($urandom), $urandom_range(1, 3), 1'b0);
            end else if (r <= 7) begin
                idx = wq[$urandom_range(0, wq.size() - 1)];
                a   = {6'($urandom), 10'(idx)};
                rd(a, $urandom_range(1, 3));
            end else if (r == 8) begin
                setsw(16'($urandom));
            end else begin
                rd(16'hFFFF, $urandom_range(1, 3));
            end
        end

        d = 16'($urandom);
        wr(16'h0030, d, 2, 1'b1);
        rd(16'h0030, 2);
        wr(16'h0031, 16'h4242, 2, 1'b0);
        rd(16'h0031, 2);
        chk("perr_sticky", {15'b0, perr}, 16'h1);

        old  = ref_mem[10'h030];
        we   = 1'b1;
        addr = 16'h0030;
        din  = ~old;
        tick();
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_data", dout, 16'h0);
        chk("mid_rst_rdy", {15'b0, rdy}, 16'h0);
        chk("mid_rst_hex", hex, 16'h0);
        chk("mid_rst_perr", {15'b0, perr}, 16'h0);
        @(negedge Clk);
        we = 1'b0;
        tick();
        Reset    = 1'b1;
        hex_ref  = 16'h0;
        perr_ref = 1'b0;
        dout_ref = 16'h0;
        sw_ref   = 16'h0;
        setsw(sw);
        rd(16'h0030, 2);
        chk("no_write_after_rst", dout, old);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
